demux_stream: RTL

//   Parametrised, registered 1:N stream demultiplexer with a valid/ready handshake and packet-locked routing.

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_stats_cnt.sv | 32 +++
 rtl/demux_stream.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the demux_stream block: FSM state encoding and counter width.
package demux_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    DROP = 2'd2
  } demux_state_e;

endpackage

// File: rtl/demux_stats_cnt.sv
// Per-channel delivered-beat counters, one CNT_W-bit wrapping counter per channel.
// Only instantiated by demux_stream when DEMUX_STATS_EN is defined.
module demux_stats_cnt
  import demux_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       hs_i,
  output logic [CNT_W*N_CH-1:0] cnt_o
);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;

      // Count one beat per completed output handshake; wraps naturally.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (hs_i[gi]) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      assign cnt_o[CNT_W*gi +: CNT_W] = cnt_q;
    end
  endgenerate

endmodule

// File: rtl/demux_stream.sv
// Registered 1:N stream demultiplexer with valid/ready handshake and packet-locked routing.
// The select is taken from a packet's first beat and held until in_last; headers with an
// out-of-range select are swallowed (with a drop_err pulse) together with the rest of the packet.
// Optional feature: define DEMUX_STATS_EN to add per-channel delivered-beat counters (beat_cnt).
module demux_stream
  import demux_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int DW   = 8,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_last,
  input  logic [SW-1:0]         in_sel,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [DW-1:0]         out_data,
  output logic                  out_last,
  output logic                  drop_err
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W*N_CH-1:0] beat_cnt
`endif
);

  demux_state_e  state_q, state_d;
  logic [SW-1:0] lock_ch_q, lock_ch_d;
  logic          reg_v_q, reg_v_d;
  logic [SW-1:0] reg_ch_q, reg_ch_d;
  logic [DW-1:0] reg_data_q, reg_data_d;
  logic          reg_last_q, reg_last_d;
  logic          drop_err_q, drop_err_d;

  logic sel_ok;
  logic wants_load;
  logic space;
  logic accept;
  logic drain;

  // Non-power-of-two channel counts leave select codes with no channel behind them.
  assign sel_ok = (32'(in_sel) < 32'(N_CH));

  // Only beats headed for the output register need space there; dropped beats are always taken.
  assign wants_load = (state_q == LOCK) || ((state_q == IDLE) && sel_ok);
  assign drain      = reg_v_q && out_ready[reg_ch_q];
  assign space      = !reg_v_q || out_ready[reg_ch_q];
  assign in_ready   = wants_load ? space : 1'b1;
  assign accept     = in_valid && in_ready;

  // Next-state: routing FSM plus output register load/drain.
  always_comb begin
    state_d    = state_q;
    lock_ch_d  = lock_ch_q;
    reg_v_d    = reg_v_q;
    reg_ch_d   = reg_ch_q;
    reg_data_d = reg_data_q;
    reg_last_d = reg_last_q;
    drop_err_d = 1'b0;

    // A drain frees the register; a load in the same cycle overrides it below (no bubble).
    if (drain) begin
      reg_v_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (sel_ok) begin
            reg_v_d    = 1'b1;
            reg_ch_d   = in_sel;
            reg_data_d = in_data;
            reg_last_d = in_last;
            if (!in_last) begin
              state_d   = LOCK;
              lock_ch_d = in_sel;
            end
          end else begin
            drop_err_d = 1'b1;
            if (!in_last) begin
              state_d = DROP;
            end
          end
        end
        LOCK: begin
          reg_v_d    = 1'b1;
          reg_ch_d   = lock_ch_q;
          reg_data_d = in_data;
          reg_last_d = in_last;
          if (in_last) begin
            state_d = IDLE;
          end
        end
        DROP: begin
          if (in_last) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output register; reset discards any held beat and returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_ch_q  <= '0;
      reg_v_q    <= 1'b0;
      reg_ch_q   <= '0;
      reg_data_q <= '0;
      reg_last_q <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_ch_q  <= lock_ch_d;
      reg_v_q    <= reg_v_d;
      reg_ch_q   <= reg_ch_d;
      reg_data_q <= reg_data_d;
      reg_last_q <= reg_last_d;
      drop_err_q <= drop_err_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_valid
      assign out_valid[gi] = reg_v_q && (32'(reg_ch_q) == gi);
    end
  endgenerate

  assign out_data = reg_data_q;
  assign out_last = reg_last_q;
  assign drop_err = drop_err_q;

`ifdef DEMUX_STATS_EN
  demux_stats_cnt #(
    .N_CH (N_CH)
  ) u_stats (
    .clk   (clk),
    .rst_n (rst_n),
    .hs_i  (out_valid & out_ready),
    .cnt_o (beat_cnt)
  );
`endif

endmodule
